pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-PC unit for the RV32IC core; replaces the bare next-PC select mux.
- Owns the architectural PC register and selects among sequential (+2 or +4 for compressed/full-width instructions), branch, JAL and JALR targets, plus a trap vector.
- Adds stall handling with a one-entry pending-redirect buffer, misaligned-target detection with automatic trap redirect and EPC capture, and a BOOT/RUN/HALT state machine.
- Sits between the decode/execute redirect logic and the instruction fetch port.

Parameters:
- XLEN, 32, width of the PC and all target buses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect target for traps and misaligned targets.
- SUPPORT_C, 1, 1 = 2-byte alignment legal (RV32IC); 0 = 4-byte alignment required.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- select  in  2  00 = sequential, 01 = branch_pc, 10 = jalr_pc, 11 = jal_pc.
- is_compressed  in  1  current instruction is 16-bit; sequential increment is 2, else 4 (forced to 4 when SUPPORT_C = 0).
- branch_pc  in  XLEN  branch target.
- jal_pc  in  XLEN  JAL target.
- jalr_pc  in  XLEN  JALR target; bit 0 is cleared internally before use.
- stall  in  1  hold PC (pipeline stall).
- trap_req  in  1  external trap request (ecall/ebreak/illegal).
- halt_req  in  1  request to enter HALT.
- resume  in  1  leave HALT.
- pc  out  XLEN  current fetch PC.
- fetch_valid  out  1  pc is a valid fetch address this cycle.
- epc  out  XLEN  PC of the instruction that trapped or produced the misaligned target.
- misalign_exc  out  1  one-cycle pulse, misaligned redirect detected.
- flush  out  1  one-cycle pulse, non-sequential PC applied.

Behaviour:
- Reset (rst = 0, asynchronous):
  - pc = RESET_PC, epc = 0, fetch_valid = 0, misalign_exc = 0, flush = 0.
  - Pending buffer empty; state = BOOT.
- BOOT:
  - Lasts exactly one cycle after rst deasserts; pc holds RESET_PC and fetch_valid = 0.
  - Then goes to RUN. All inputs are ignored in BOOT.
- RUN: fetch_valid = 1. Next-PC priority, evaluated each rising edge:
  1. trap_req: pc <= TRAP_VEC, epc <= pc, flush = 1, pending cleared. Ignores stall.
  2. Redirect (select != 00) with a misaligned target: pc <= TRAP_VEC, epc <= pc, misalign_exc = 1, flush = 1. Ignores stall.
     - Misaligned means target[0] = 1, or target[1] = 1 when SUPPORT_C = 0.
  3. stall = 1:
     - pc holds.
     - A legal redirect is written to the pending buffer; a newer redirect overwrites an older one.
  4. stall = 0 and pending valid: pc <= pending target, flush = 1, pending cleared. A same-cycle legal redirect has priority over the pending one and replaces it.
  5. stall = 0, legal redirect: pc <= target, flush = 1.
  6. Otherwise: pc <= pc + (is_compressed ? 2 : 4), modulo 2^XLEN, wrapping silently.
- halt_req in RUN:
  - Takes effect only if no trap or misalign occurs that cycle; otherwise the trap wins and halt_req is ignored.
  - Moves to HALT; pc holds and any pending redirect is kept.
- HALT:
  - fetch_valid = 0; pc holds.
  - resume goes to RUN; the pending redirect, if any, is applied on the first RUN edge with stall = 0.
  - trap_req in HALT goes to RUN with pc <= TRAP_VEC and epc <= pc.
  - halt_req and resume together: resume wins.
- Outputs and latency:
  - misalign_exc and flush are registered, high for exactly the cycle after the triggering edge.
  - Redirect latency is one cycle from input to pc.
- epc changes only on trap or misalign.

Test Plan:
- Reset then release, 4 full instructions → pc = 0 for the BOOT cycle and first RUN cycle, then 4, 8, 12, 16; fetch_valid rises one cycle after rst deasserts.
- pc = 0x10, mixed is_compressed = 1,0,1 → pc = 0x12, 0x16, 0x18.
- pc = 0x20, select = 01, branch_pc = 0x80, stall = 1 for 3 cycles → pc holds 0x20; after stall drops, pc = 0x80 and flush pulses once.
- SUPPORT_C = 0, pc = 0x40, select = 11, jal_pc = 0x42 → pc = 0x100, epc = 0x40, misalign_exc = 1 for one cycle.
- select = 10, jalr_pc = 0x201 → pc = 0x200, no exception.
- trap_req together with stall and a legal branch at pc = 0x30 → pc = 0x100, epc = 0x30, pending cleared.
- Halt at pc = 0x50, hold 5 cycles, resume → fetch_valid = 0 while halted; pc resumes at 0x50 then 0x54.
- rst asserted mid-stall with pending valid → pc = RESET_PC immediately, pending cleared, BOOT re-entered.
- pc = 0xFFFF_FFFC, sequential step → pc = 0x0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC unit for an RV32IC core.
// Owns the architectural PC and picks the next fetch address from sequential (+2/+4), branch,
// JAL, JALR or the trap vector. Redirects that arrive during a stall (or a halt request) are
// parked in a one-entry pending buffer. Misaligned redirect targets trap to TRAP_VEC and
// capture the faulting PC in epc. A BOOT/RUN/HALT machine gates fetch_valid.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   select         00 sequential, 01 branch_pc, 10 jalr_pc, 11 jal_pc
//   is_compressed  current instruction is 16-bit (step 2 instead of 4 when SUPPORT_C = 1)
//   branch_pc      branch target
//   jal_pc         JAL target
//   jalr_pc        JALR target, bit 0 cleared internally
//   stall          hold PC
//   trap_req       trap request (ecall/ebreak/illegal)
//   halt_req       request to enter HALT
//   resume         leave HALT
//   pc             current fetch PC
//   fetch_valid    pc is a valid fetch address
//   epc            PC of the trapping / misaligned-redirect instruction
//   misalign_exc   one-cycle pulse after a misaligned redirect
//   flush          one-cycle pulse after any non-sequential PC update
module pc_sequencer #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter logic [XLEN-1:0]      TRAP_VEC  = XLEN'(32'h0000_0100),
  parameter bit                   SUPPORT_C = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      select,
  input  logic            is_compressed,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] jal_pc,
  input  logic [XLEN-1:0] jalr_pc,
  input  logic            stall,
  input  logic            trap_req,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic            fetch_valid,
  output logic [XLEN-1:0] epc,
  output logic            misalign_exc,
  output logic            flush
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] pend_pc_q;
  logic            pend_valid_q;
  logic            fetch_valid_q;
  logic            flush_q;
  logic            misalign_q;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] step;
  logic            redirect;
  logic            misaligned;
  logic            bad_redirect;
  logic            legal_redirect;
  logic            unused_jalr_lsb;

  assign unused_jalr_lsb = jalr_pc[0];

  always_comb begin
    target = '0;
    unique case (select)
      2'b01:   target = branch_pc;
      2'b10:   target = {jalr_pc[XLEN-1:1], 1'b0};
      2'b11:   target = jal_pc;
      default: target = '0;
    endcase
  end

  always_comb begin
    redirect       = (select != 2'b00);
    // Without the C extension every instruction is word-aligned, so bit 1 is illegal too.
    misaligned     = target[0] | (!SUPPORT_C & target[1]);
    bad_redirect   = redirect & misaligned;
    legal_redirect = redirect & !misaligned;
    step           = (SUPPORT_C && is_compressed) ? XLEN'(2) : XLEN'(4);
    seq_pc         = pc_q + step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      epc_q         <= '0;
      pend_pc_q     <= '0;
      pend_valid_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q       <= StRun;
          fetch_valid_q <= 1'b1;
        end
        StRun: begin
          if (trap_req || bad_redirect) begin
            // Traps and misaligned targets ignore stall and beat a same-cycle halt request.
            pc_q         <= TRAP_VEC;
            epc_q        <= pc_q;
            flush_q      <= 1'b1;
            misalign_q   <= !trap_req;
            pend_valid_q <= 1'b0;
          end else if (stall || halt_req) begin
            // PC holds; park a legal redirect so it is not lost across the stall or halt.
            if (legal_redirect) begin
              pend_valid_q <= 1'b1;
              pend_pc_q    <= target;
            end
            if (halt_req) begin
              state_q       <= StHalt;
              fetch_valid_q <= 1'b0;
            end
          end else if (legal_redirect) begin
            // A fresh redirect supersedes whatever is pending.
            pc_q         <= target;
            flush_q      <= 1'b1;
            pend_valid_q <= 1'b0;
          end else if (pend_valid_q) begin
            pc_q         <= pend_pc_q;
            flush_q      <= 1'b1;
            pend_valid_q <= 1'b0;
          end else begin
            pc_q <= seq_pc;
          end
        end
        StHalt: begin
          if (trap_req) begin
            pc_q          <= TRAP_VEC;
            epc_q         <= pc_q;
            flush_q       <= 1'b1;
            pend_valid_q  <= 1'b0;
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
          end else if (resume) begin
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= StBoot;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = pc_q;
  assign epc          = epc_q;
  assign fetch_valid  = fetch_valid_q;
  assign flush        = flush_q;
  assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (SUPPORT_C = 0 and 1) share one stimulus stream and
// are compared every cycle against a behavioural model, plus directed constant checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  select;
  logic        is_compressed;
  logic [31:0] branch_pc, jal_pc, jalr_pc;
  logic        stall, trap_req, halt_req, resume;

  logic [31:0] pc0, pc1, epc0, epc1;
  logic        fv0, fv1, mis0, mis1, fl0, fl1;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = no C extension, 1 = C extension. m_st: 0 boot, 1 run, 2 halted.
  int          m_st  [2];
  logic [31:0] m_pc  [2];
  logic [31:0] m_epc [2];
  logic [31:0] m_pt  [2];
  bit          m_pv  [2];
  bit          m_fl  [2];
  bit          m_mis [2];

  always #5 clk = ~clk;

  pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .SUPPORT_C(1'b0)) dut0 (
    .clk(clk), .rst(rst), .select(select), .is_compressed(is_compressed),
    .branch_pc(branch_pc), .jal_pc(jal_pc), .jalr_pc(jalr_pc), .stall(stall),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume), .pc(pc0),
    .fetch_valid(fv0), .epc(epc0), .misalign_exc(mis0), .flush(fl0)
  );

  pc_sequencer #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .SUPPORT_C(1'b1)) dut1 (
    .clk(clk), .rst(rst), .select(select), .is_compressed(is_compressed),
    .branch_pc(branch_pc), .jal_pc(jal_pc), .jalr_pc(jalr_pc), .stall(stall),
    .trap_req(trap_req), .halt_req(halt_req), .resume(resume), .pc(pc1),
    .fetch_valid(fv1), .epc(epc1), .misalign_exc(mis1), .flush(fl1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_pc[k] = 32'h0; m_epc[k] = 32'h0; m_pt[k] = 32'h0;
      m_pv[k] = 1'b0; m_fl[k] = 1'b0; m_mis[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k);
    logic [31:0] tgt;
    logic [31:0] align;
    bit          redir, bad;
    redir = (select != 2'b00);
    case (select)
      2'b01:   tgt = branch_pc;
      2'b10:   tgt = jalr_pc & 32'hFFFF_FFFE;
      2'b11:   tgt = jal_pc;
      default: tgt = 32'h0;
    endcase
    align = (k == 1) ? 32'd2 : 32'd4;
    bad   = redir && ((tgt % align) != 32'd0);
    m_fl[k]  = 1'b0;
    m_mis[k] = 1'b0;
    if (m_st[k] == 0) begin
      m_st[k] = 1;
    end else if (m_st[k] == 1) begin
      if (trap_req || bad) begin
        m_epc[k] = m_pc[k]; m_pc[k] = 32'h100; m_fl[k] = 1'b1;
        m_mis[k] = !trap_req; m_pv[k] = 1'b0;
      end else if (stall || halt_req) begin
        if (redir) begin m_pv[k] = 1'b1; m_pt[k] = tgt; end
        if (halt_req) m_st[k] = 2;
      end else if (redir) begin
        m_pc[k] = tgt; m_fl[k] = 1'b1; m_pv[k] = 1'b0;
      end else if (m_pv[k]) begin
        m_pc[k] = m_pt[k]; m_fl[k] = 1'b1; m_pv[k] = 1'b0;
      end else begin
        m_pc[k] = m_pc[k] + ((k == 1 && is_compressed) ? 32'd2 : 32'd4);
      end
    end else begin
      if (trap_req) begin
        m_epc[k] = m_pc[k]; m_pc[k] = 32'h100; m_fl[k] = 1'b1; m_pv[k] = 1'b0; m_st[k] = 1;
      end else if (resume) begin
        m_st[k] = 1;
      end
    end
  endtask

  task automatic cmp_model();
    chk("c0_pc", pc0, m_pc[0]);
    chk("c0_epc", epc0, m_epc[0]);
    chk("c0_fetch_valid", 32'(fv0), 32'(m_st[0] == 1));
    chk("c0_flush", 32'(fl0), 32'(m_fl[0]));
    chk("c0_misalign", 32'(mis0), 32'(m_mis[0]));
    chk("c1_pc", pc1, m_pc[1]);
    chk("c1_epc", epc1, m_epc[1]);
    chk("c1_fetch_valid", 32'(fv1), 32'(m_st[1] == 1));
    chk("c1_flush", 32'(fl1), 32'(m_fl[1]));
    chk("c1_misalign", 32'(mis1), 32'(m_mis[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    cmp_model();
  endtask

  task automatic idle_inputs();
    select = 2'b00; is_compressed = 1'b0; stall = 1'b0;
    trap_req = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic jump(input logic [31:0] t);
    select = 2'b11; jal_pc = t;
    step();
    select = 2'b00;
  endtask

  initial begin
    idle_inputs();
    branch_pc = 32'h0; jal_pc = 32'h0; jalr_pc = 32'h0;
    rst = 1'b0;
    model_reset();
    #12;
    chk("reset_pc", pc1, 32'h0);
    chk("reset_fv", 32'(fv1), 32'h0);
    chk("reset_epc", epc0, 32'h0);
    cmp_model();
    @(posedge clk); #1;
    rst = 1'b1;

    // Boot cycle then four full-width instructions.
    step(); chk("boot_pc", pc1, 32'h0); chk("boot_fv", 32'(fv1), 32'h1);
    step(); chk("seq_4", pc1, 32'h4);
    step(); chk("seq_8", pc1, 32'h8);
    step(); chk("seq_c", pc1, 32'hC);
    step(); chk("seq_10", pc1, 32'h10);

    // Mixed compressed stepping.
    is_compressed = 1'b1; step(); chk("mix_12", pc1, 32'h12);
    is_compressed = 1'b0; step(); chk("mix_16", pc1, 32'h16);
    is_compressed = 1'b1; step(); chk("mix_18", pc1, 32'h18);
    is_compressed = 1'b0;

    // Branch arriving during a 3-cycle stall is applied when the stall drops.
    jump(32'h20);
    select = 2'b01; branch_pc = 32'h80; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("stall_hold", pc1, 32'h20); chk("stall_noflush", 32'(fl1), 32'h0);
    end
    select = 2'b00; stall = 1'b0;
    step(); chk("pend_apply", pc1, 32'h80); chk("pend_flush", 32'(fl1), 32'h1);
    step(); chk("pend_once", 32'(fl1), 32'h0); chk("pend_next", pc1, 32'h84);

    // JAL to 0x42: misaligned without C, legal with C.
    jump(32'h40);
    select = 2'b11; jal_pc = 32'h42;
    step();
    chk("mis_pc", pc0, 32'h100); chk("mis_epc", epc0, 32'h40); chk("mis_exc", 32'(mis0), 32'h1);
    chk("mis_c_pc", pc1, 32'h42); chk("mis_c_exc", 32'(mis1), 32'h0);
    select = 2'b00;
    step(); chk("mis_pulse", 32'(mis0), 32'h0);

    // JALR clears bit 0.
    select = 2'b10; jalr_pc = 32'h201;
    step(); chk("jalr_pc", pc1, 32'h200); chk("jalr_noexc", 32'(mis1), 32'h0);
    select = 2'b00;

    // Trap beats stall and a legal branch; pending is discarded.
    jump(32'h30);
    trap_req = 1'b1; stall = 1'b1; select = 2'b01; branch_pc = 32'h60;
    step(); chk("trap_pc", pc1, 32'h100); chk("trap_epc", epc1, 32'h30);
    idle_inputs();
    step(); chk("trap_nopend", pc1, 32'h104);

    // Halt for several cycles then resume.
    jump(32'h50);
    halt_req = 1'b1; step(); chk("halt_pc", pc1, 32'h50); chk("halt_fv", 32'(fv1), 32'h0);
    halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk("halted_fv", 32'(fv1), 32'h0);
    end
    resume = 1'b1; step(); chk("resume_pc", pc1, 32'h50); chk("resume_fv", 32'(fv1), 32'h1);
    resume = 1'b0; step(); chk("resume_next", pc1, 32'h54);

    // Asynchronous reset while a redirect is pending.
    select = 2'b01; branch_pc = 32'h80; stall = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("async_pc", pc1, 32'h0); chk("async_fv", 32'(fv1), 32'h0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b1;
    step(); chk("reboot_pc", pc1, 32'h0);
    step(); chk("reboot_nopend", pc1, 32'h4);

    // Wrap at the top of the address space.
    jump(32'hFFFF_FFFC);
    step(); chk("wrap", pc1, 32'h0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      select        = 2'($urandom_range(0, 3));
      is_compressed = 1'($urandom_range(0, 1));
      branch_pc     = $urandom & 32'h0000_FFFE;
      jal_pc        = $urandom & 32'h0000_FFFE;
      jalr_pc       = $urandom;
      if ($urandom_range(0, 7) == 0) branch_pc = branch_pc | 32'h1;
      stall    = ($urandom_range(0, 3) == 0);
      trap_req = ($urandom_range(0, 19) == 0);
      halt_req = ($urandom_range(0, 24) == 0);
      resume   = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
